// File: rtl/vram_arb_pkg.sv
// ============================================================================
// Module : vram_arb_pkg
// Brief  : Shared state encoding and default sizing for vram_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vram_arb_pkg;

  localparam int C_DEF_AW           = 16;
  localparam int C_DEF_DW           = 16;
  localparam int C_DEF_STARVE_LIMIT = 4;
  localparam int C_DEF_RD_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } arb_state_e;

endpackage : vram_arb_pkg

`default_nettype wire

// File: rtl/vram_port_arbiter.sv
// ============================================================================
// Module : vram_port_arbiter
// Brief  : Shares one SDRAM FIFO port between the game writer and display reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = C_DEF_STARVE_LIMIT,
  parameter int RD_TIMEOUT   = C_DEF_RD_TIMEOUT,
  parameter int AW           = C_DEF_AW,
  parameter int DW           = C_DEF_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vs,
  input  logic          wreq,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          wack,
  input  logic          rreq,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          rerr,
  output logic          write,
  output logic [AW-1:0] writeaddr,
  output logic [DW-1:0] writedata,
  input  logic          wr_full,
  output logic          read,
  output logic [AW-1:0] readaddr,
  input  logic          rd_empty,
  input  logic [DW-1:0] readdata,
  output logic          busy
);

  localparam int C_SW = $clog2(STARVE_LIMIT + 1);
  localparam int C_TW = $clog2(RD_TIMEOUT + 1);

  arb_state_e      state_q,  state_d;
  logic [C_SW-1:0] starve_q, starve_d;
  logic [C_TW-1:0] tmo_q,    tmo_d;
  logic [AW-1:0]   waddr_q,  waddr_d;
  logic [DW-1:0]   wdata_q,  wdata_d;
  logic [AW-1:0]   raddr_q,  raddr_d;
  logic [DW-1:0]   rdata_q,  rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            rerr_q,   rerr_d;

  logic w_wr_elig;
  logic w_starved;
  logic w_grant_wr;
  logic w_grant_rd;

  // Writer wins during blanking, when the reader is idle, or once starved.
  assign w_wr_elig  = wreq & ~wr_full;
  assign w_starved  = (starve_q == C_SW'(STARVE_LIMIT));
  assign w_grant_wr = w_wr_elig & (vs | ~rreq | w_starved);
  assign w_grant_rd = rreq & ~w_grant_wr;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = '0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_grant_wr) begin
          state_d  = WR_ISSUE;
          waddr_d  = waddr;
          wdata_d  = wdata;
          starve_d = '0;
        end else if (w_grant_rd) begin
          state_d = RD_ISSUE;
          raddr_d = raddr;
          if (!wreq) begin
            starve_d = '0;
          end else if (!w_starved) begin
            starve_d = starve_q + C_SW'(1);
          end
        end else if (!wreq) begin
          starve_d = '0;
        end
      end
      WR_ISSUE: state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (!rd_empty) begin
          rdata_d  = readdata;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else if (tmo_q == C_TW'(RD_TIMEOUT - 1)) begin
          rerr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + C_TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  // FIFO address/data buses are only driven while their strobe is high.
  assign write     = (state_q == WR_ISSUE);
  assign wack      = write;
  assign writeaddr = write ? waddr_q : '0;
  assign writedata = write ? wdata_q : '0;
  assign read      = (state_q == RD_ISSUE);
  assign readaddr  = read ? raddr_q : '0;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign rerr      = rerr_q;

endmodule : vram_port_arbiter

`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
// ============================================================================
// Module : tb_vram_port_arbiter
// Brief  : Randomized self-checking bench for vram_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int RD_TIMEOUT   = 255;
  localparam int AW           = 16;
  localparam int DW           = 16;

  logic          clk = 1'b0;
  logic          reset_n, vs, wreq, rreq, wr_full, rd_empty;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, readdata;
  logic          wack, rvalid, rerr, write, read, busy;
  logic [AW-1:0] writeaddr, readaddr;
  logic [DW-1:0] writedata, rdata;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT), .RD_TIMEOUT(RD_TIMEOUT), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs(vs),
    .wreq(wreq), .waddr(waddr), .wdata(wdata), .wack(wack),
    .rreq(rreq), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .rerr(rerr),
    .write(write), .writeaddr(writeaddr), .writedata(writedata), .wr_full(wr_full),
    .read(read), .readaddr(readaddr), .rd_empty(rd_empty), .readdata(readdata),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: timestamps of when the port is next free / when the
  // read wait window opens, plus the arbitration rules.
  int            t = 0;
  bit            m_rd_active = 0;
  int            m_wait_from = 0;
  int            m_idle_from = 0;
  int            m_starve    = 0;
  bit            m_in_reset  = 0;
  logic [AW-1:0] m_wa = '0, m_ra = '0;
  logic [DW-1:0] m_wd = '0, m_rdata = '0;
  bit            e_write, e_read, e_rvalid, e_rerr, e_busy;

  task automatic model_step();
    bit gw, gr, w_el;
    t++;
    e_write = 0; e_read = 0; e_rvalid = 0; e_rerr = 0;
    m_in_reset = !reset_n;
    if (!reset_n) begin
      m_rd_active = 0; m_idle_from = t + 1; m_starve = 0;
      m_wa = '0; m_wd = '0; m_ra = '0; m_rdata = '0;
    end else if (m_rd_active) begin
      if (t >= m_wait_from) begin
        if (!rd_empty) begin
          m_rdata = readdata; e_rvalid = 1; m_rd_active = 0; m_idle_from = t + 1;
        end else if (t - m_wait_from + 1 == RD_TIMEOUT) begin
          e_rerr = 1; m_rd_active = 0; m_idle_from = t + 1;
        end
      end
    end else if (t >= m_idle_from) begin
      w_el = wreq && !wr_full;
      gw   = vs ? w_el : (w_el && (!rreq || m_starve == STARVE_LIMIT));
      gr   = rreq && !gw;
      if (gw) begin
        m_wa = waddr; m_wd = wdata; e_write = 1; m_idle_from = t + 2; m_starve = 0;
      end else if (gr) begin
        m_ra = raddr; e_read = 1; m_rd_active = 1; m_wait_from = t + 2;
        m_starve = wreq ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
      end else if (!wreq) begin
        m_starve = 0;
      end
    end
    e_busy = m_rd_active || (t + 1 < m_idle_from);
  endtask

  task automatic check_outputs();
    check_val("write",  32'(write),  32'(e_write));
    check_val("wack",   32'(wack),   32'(e_write));
    check_val("read",   32'(read),   32'(e_read));
    check_val("rvalid", 32'(rvalid), 32'(e_rvalid));
    check_val("rerr",   32'(rerr),   32'(e_rerr));
    check_val("busy",   32'(busy),   32'(e_busy));
    check_val("rdata",  32'(rdata),  32'(m_rdata));
    if (e_write) begin
      check_val("writeaddr", 32'(writeaddr), 32'(m_wa));
      check_val("writedata", 32'(writedata), 32'(m_wd));
    end
    if (e_read) check_val("readaddr", 32'(readaddr), 32'(m_ra));
    if (m_in_reset) begin
      check_val("rst_writeaddr", 32'(writeaddr), 32'd0);
      check_val("rst_writedata", 32'(writedata), 32'd0);
      check_val("rst_readaddr",  32'(readaddr),  32'd0);
    end
  endtask

  task automatic update_req();
    if (wreq) begin
      if (e_write) wreq = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 49) == 0) wreq = 1'b0;
    end else begin
      wreq = ($urandom_range(0, 2) == 0);
    end
    if (rreq) begin
      if (e_rvalid || e_rerr) rreq = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 49) == 0) rreq = 1'b0;
    end else begin
      rreq = ($urandom_range(0, 2) == 0);
    end
  endtask

  // mode 0: random, 1: full contention, 2: rd_empty stuck, 3: hold inputs
  task automatic next_inputs(input int mode);
    if (mode != 3) begin
      waddr = AW'($urandom); wdata = DW'($urandom);
      raddr = AW'($urandom); readdata = DW'($urandom);
    end
    case (mode)
      0: begin
        if ($urandom_range(0, 19) == 0) vs = ~vs;
        wr_full  = ($urandom_range(0, 3) == 0);
        rd_empty = ($urandom_range(0, 2) != 0);
        reset_n  = ($urandom_range(0, 299) != 0);
        update_req();
      end
      1: begin
        wreq = 1'b1; rreq = 1'b1; wr_full = 1'b0; reset_n = 1'b1;
        rd_empty = 1'($urandom_range(0, 1));
      end
      2: begin
        rd_empty = 1'b1; wr_full = 1'b0; reset_n = 1'b1;
        update_req();
      end
      default: ;
    endcase
  endtask

  task automatic step(input int mode);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    next_inputs(mode);
  endtask

  initial begin
    bit reached;
    reset_n = 1'b0; vs = 1'b0; wreq = 1'b1; rreq = 1'b1;
    wr_full = 1'b0; rd_empty = 1'b1;
    waddr = 16'h0002; wdata = 16'h0002; raddr = 16'h0003; readdata = 16'h0003;

    repeat (3) step(3);
    reset_n = 1'b1;
    repeat (5) step(3);
    rd_empty = 1'b0;
    repeat (4) step(3);

    repeat (4000) step(0);
    vs = 1'b0;
    repeat (80) step(1);
    vs = 1'b1;
    repeat (40) step(1);
    vs = 1'b0;
    repeat (1500) step(2);
    vs = 1'b1;
    repeat (600) step(2);

    // Abandon a read in the middle of its wait window.
    reset_n = 1'b1; vs = 1'b0; wreq = 1'b0; rreq = 1'b1; rd_empty = 1'b1; wr_full = 1'b0;
    reached = 0;
    for (int i = 0; i < 600 && !reached; i++) begin
      step(3);
      reached = m_rd_active && (t > m_wait_from + 3);
    end
    check_val("mid_read_reached", 32'(reached), 32'd1);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1; rreq = 1'b0;
    repeat (3) step(3);
    rreq = 1'b1; wreq = 1'b1;
    repeat (300) step(3);

    vs = 1'b0;
    repeat (600) step(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vram_port_arbiter

`default_nettype wire
